pattern_seq_detector: RTL and testbench
=======================================

PATTERN_SEQ_DETECTOR -- requirements
Module: pattern_seq_detector

Interface
REQ-001 Parameter PAT_W, default 4: detected pattern length in bits, legal range 2..8.
REQ-002 Parameter HIST_W, default 7: input history width shown to the user, legal range 1..16.
REQ-003 Parameter CNT_W, default 8: match counter width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 bit0_pulse  in  1  one-cycle strobe: shift in a 0 (debounced button pulse).
REQ-007 bit1_pulse  in  1  one-cycle strobe: shift in a 1.
REQ-008 pattern  in  PAT_W  target pattern; MSB is the oldest bit, LSB the newest.
REQ-009 overlap_en  in  1  1 = overlapping matches allowed; 0 = window restarts after each match.
REQ-010 clear  in  1  synchronous clear of history, window, latch and counter.
REQ-011 match_pulse  out  1  one-cycle strobe on each detected match.
REQ-012 match_latch  out  1  sticky match indicator for LED display.
REQ-013 match_count  out  CNT_W  saturating number of matches.
REQ-014 history  out  HIST_W  last HIST_W accepted bits; LSB is the newest.
REQ-015 state  out  2  FSM state for debug: 00 EMPTY, 01 FILL, 10 ARMED.

Function
REQ-016 Accepted bit: exactly one of bit0_pulse or bit1_pulse is high in a cycle; if both are high, the SHALL be ignored and no register changes.
REQ-017 On an accepted bit: history and window shift left with the new bit at the LSB; fill count increments, saturating at PAT_W.
REQ-018 FSM: EMPTY -> FILL on the first accepted bit; FILL -> ARMED when fill reaches PAT_W; ARMED holds; clear returns the FSM to EMPTY.
REQ-019 Match condition: the post-shift window equals pattern and the post-shift fill equals PAT_W, evaluated in the same cycle the bit is accepted.
REQ-020 Latency: match_pulse, match_latch and match_count all update at the clock edge that registers the matching bit, so they are visible one cycle after the strobe.
REQ-021 match_pulse is high for exactly one cycle per match and low at all other times.
REQ-022 match_latch clears on any accepted bit that does not produce a match; it sets on a match; otherwise it holds.
REQ-023 match_count increments by 1 on each match and saturates at 2^CNT_W-1 with no wrap.
REQ-024 overlap_en=0 on a match: fill is set to 0, the window is zeroed and the FSM goes to EMPTY; history is unaffected.
REQ-025 overlap_en=1 on a match: fill stays PAT_W and the FSM stays ARMED.
REQ-026 pattern and overlap_en are sampled only in cycles where a bit is accepted; changing them between bits has no other effect.
REQ-027 clear has priority over an accepted bit in the same cycle; clear zeroes all outputs and the FSM goes to EMPTY.
REQ-028 Only history bits [HIST_W-1:0] are retained; older bits are discarded.

Reset
REQ-029 While reset_n=0: history, window, fill, match_count, match_pulse and match_latch are all 0, and the FSM is in EMPTY.
REQ-030 Reset asserted mid-sequence discards partial fill; the first PAT_W bits after release are required before any match.

Verification
REQ-031 PAT_W=4, pattern=1011, overlap_en=0: bits 1,0,1,1 -> match_pulse one cycle after the 4th strobe, count=1, latch=1, state=00.
REQ-032 pattern=1011, overlap_en=1: bits 1,0,1,1,0,1,1 -> two matches (after bits 4 and 7), count=2; with overlap_en=0 -> count=1.
REQ-033 bit0_pulse and bit1_pulse high in the same cycle -> history, fill and count unchanged, and no pulse.
REQ-034 CNT_W=2, repeated matches of pattern 1111 with overlap -> count reaches 3 and stays at 3.
REQ-035 reset_n low after bits 1,0,1, then release, then bit 1 -> no match, history=0000001, state=01.
REQ-036 clear and bit1_pulse in the same cycle -> all outputs 0, state=00, and the bit is not shifted in.

Source files
------------

// File: rtl/pattern_seq_detector.sv
// rtl/pattern_seq_detector.sv - serial bit-pattern detector with history, match latch and counter
module pattern_seq_detector #(
  parameter int PAT_W  = 4,
  parameter int HIST_W = 7,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bit0_pulse,
  input  logic              bit1_pulse,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              overlap_en,
  input  logic              clear,
  output logic              match_pulse,
  output logic              match_latch,
  output logic [CNT_W-1:0]  match_count,
  output logic [HIST_W-1:0] history,
  output logic [1:0]        state
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FILL  = 2'b01,
    ST_ARMED = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [PAT_W-1:0]    window_q, window_d;
  logic [HIST_W-1:0]   history_q, history_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                pulse_q, pulse_d;
  logic                latch_q, latch_d;

  logic                accept;
  logic [PAT_W-1:0]    win_shift;
  logic [FILL_W-1:0]   fill_inc;
  logic                hit;

  // Both strobes high at once is ambiguous, so such a cycle is simply dropped.
  assign accept    = bit0_pulse ^ bit1_pulse;
  assign win_shift = (window_q << 1) | PAT_W'(bit1_pulse);
  assign fill_inc  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
  assign hit       = (win_shift == pattern) && (fill_inc == FILL_FULL);

  always_comb begin
    state_d   = state_q;
    window_d  = window_q;
    history_d = history_q;
    fill_d    = fill_q;
    count_d   = count_q;
    latch_d   = latch_q;
    pulse_d   = 1'b0;

    if (clear) begin
      state_d   = ST_EMPTY;
      window_d  = '0;
      history_d = '0;
      fill_d    = '0;
      count_d   = '0;
      latch_d   = 1'b0;
    end else if (accept) begin
      history_d = (history_q << 1) | HIST_W'(bit1_pulse);
      if (hit) begin
        pulse_d = 1'b1;
        latch_d = 1'b1;
        if (count_q != '1) count_d = count_q + 1'b1;
        if (overlap_en) begin
          window_d = win_shift;
          fill_d   = fill_inc;
          state_d  = ST_ARMED;
        end else begin
          window_d = '0;
          fill_d   = '0;
          state_d  = ST_EMPTY;
        end
      end else begin
        latch_d  = 1'b0;
        window_d = win_shift;
        fill_d   = fill_inc;
        state_d  = (fill_inc == FILL_FULL) ? ST_ARMED : ST_FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_EMPTY;
      window_q  <= '0;
      history_q <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      pulse_q   <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      window_q  <= window_d;
      history_q <= history_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      pulse_q   <= pulse_d;
      latch_q   <= latch_d;
    end
  end

  assign match_pulse = pulse_q;
  assign match_latch = latch_q;
  assign match_count = count_q;
  assign history     = history_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pattern_seq_detector.sv
// tb/tb_pattern_seq_detector.sv - directed self-checking bench for pattern_seq_detector
module tb_pattern_seq_detector;

  logic       clk;
  logic       reset_n;
  logic       bit0_pulse;
  logic       bit1_pulse;
  logic [3:0] pattern;
  logic       overlap_en;
  logic       clear;

  logic       match_pulse, match_latch;
  logic [7:0] match_count;
  logic [6:0] history;
  logic [1:0] state;

  logic       m2_pulse, m2_latch;
  logic [1:0] m2_count;
  logic [6:0] m2_history;
  logic [1:0] m2_state;

  int n_checks = 0;
  int n_pass   = 0;

  pattern_seq_detector #(.PAT_W(4), .HIST_W(7), .CNT_W(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .bit0_pulse(bit0_pulse), .bit1_pulse(bit1_pulse),
    .pattern(pattern), .overlap_en(overlap_en), .clear(clear),
    .match_pulse(match_pulse), .match_latch(match_latch), .match_count(match_count),
    .history(history), .state(state)
  );

  pattern_seq_detector #(.PAT_W(4), .HIST_W(7), .CNT_W(2)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .bit0_pulse(bit0_pulse), .bit1_pulse(bit1_pulse),
    .pattern(pattern), .overlap_en(overlap_en), .clear(clear),
    .match_pulse(m2_pulse), .match_latch(m2_latch), .match_count(m2_count),
    .history(m2_history), .state(m2_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Strobe held for one rising edge; returns on the following falling edge.
  task automatic send_bit(input logic b);
    @(negedge clk);
    bit0_pulse = ~b;
    bit1_pulse = b;
    @(negedge clk);
    bit0_pulse = 1'b0;
    bit1_pulse = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; bit0_pulse = 1'b0; bit1_pulse = 1'b0;
    pattern = 4'b1011; overlap_en = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_history", 32'(history), 32'h0);
    check("rst_count",   32'(match_count), 32'h0);
    check("rst_pulse",   32'(match_pulse), 32'h0);
    check("rst_latch",   32'(match_latch), 32'h0);
    check("rst_state",   32'(state), 32'h0);
    reset_n = 1'b1;

    // Single non-overlapping match of 1011
    send_bit(1'b1);
    check("fill_state", 32'(state), 32'h1);
    check("fill_hist",  32'(history), 32'h01);
    send_bit(1'b0);
    send_bit(1'b1);
    check("pre_pulse", 32'(match_pulse), 32'h0);
    send_bit(1'b1);
    check("m1_pulse", 32'(match_pulse), 32'h1);
    check("m1_count", 32'(match_count), 32'h1);
    check("m1_latch", 32'(match_latch), 32'h1);
    check("m1_state", 32'(state), 32'h0);
    check("m1_hist",  32'(history), 32'h0B);
    @(negedge clk);
    check("m1_pulse_drop", 32'(match_pulse), 32'h0);
    check("m1_latch_hold", 32'(match_latch), 32'h1);

    do_clear();
    check("clr_count", 32'(match_count), 32'h0);
    check("clr_latch", 32'(match_latch), 32'h0);
    check("clr_hist",  32'(history), 32'h0);

    // Overlapping: 1,0,1,1,0,1,1 gives two matches
    overlap_en = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check("ov_m1_pulse", 32'(match_pulse), 32'h1);
    check("ov_m1_state", 32'(state), 32'h2);
    send_bit(1'b0);
    check("ov_nm_latch", 32'(match_latch), 32'h0);
    check("ov_nm_pulse", 32'(match_pulse), 32'h0);
    send_bit(1'b1); send_bit(1'b1);
    check("ov_m2_pulse", 32'(match_pulse), 32'h1);
    check("ov_m2_count", 32'(match_count), 32'h2);
    check("ov_hist",     32'(history), 32'h5B);

    // Same bits without overlap: only one match
    do_clear();
    overlap_en = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check("nov_pulse", 32'(match_pulse), 32'h0);
    check("nov_count", 32'(match_count), 32'h1);
    check("nov_state", 32'(state), 32'h1);

    // Both strobes together: dropped
    @(negedge clk);
    bit0_pulse = 1'b1; bit1_pulse = 1'b1;
    @(negedge clk);
    bit0_pulse = 1'b0; bit1_pulse = 1'b0;
    check("both_hist",  32'(history), 32'h5B);
    check("both_count", 32'(match_count), 32'h1);
    check("both_pulse", 32'(match_pulse), 32'h0);
    check("both_state", 32'(state), 32'h1);
    send_bit(1'b1);
    check("after_both_state", 32'(state), 32'h2);

    // Saturation on the 2-bit counter instance with 1111 overlapping
    do_clear();
    pattern = 4'b1111; overlap_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send_bit(1'b1);
      if (i == 5) check("sat_cnt_b5", 32'(m2_count), 32'h2);
      if (i == 6) check("sat_cnt_b6", 32'(m2_count), 32'h3);
    end
    check("sat_cnt_b8",  32'(m2_count), 32'h3);
    check("wide_cnt_b8", 32'(match_count), 32'h5);
    check("sat_pulse_b8", 32'(m2_pulse), 32'h1);

    // Reset mid-sequence discards partial fill
    do_clear();
    pattern = 4'b1011; overlap_en = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    check("mid_rst_hist",  32'(history), 32'h0);
    check("mid_rst_state", 32'(state), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    send_bit(1'b1);
    check("post_rst_pulse", 32'(match_pulse), 32'h0);
    check("post_rst_hist",  32'(history), 32'h01);
    check("post_rst_state", 32'(state), 32'h1);

    // Clear wins over a bit in the same cycle
    do_clear();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check("pre_clr_latch", 32'(match_latch), 32'h1);
    @(negedge clk);
    clear = 1'b1; bit1_pulse = 1'b1;
    @(negedge clk);
    clear = 1'b0; bit1_pulse = 1'b0;
    check("cb_hist",  32'(history), 32'h0);
    check("cb_count", 32'(match_count), 32'h0);
    check("cb_latch", 32'(match_latch), 32'h0);
    check("cb_pulse", 32'(match_pulse), 32'h0);
    check("cb_state", 32'(state), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
